// File: rtl/fifo_burst_drain_if.sv
// rtl/fifo_burst_drain_if.sv - FIFO read port, byte stream and status bundle for fifo_burst_drain
interface fifo_burst_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_DATA;
  logic                  fifo_rd_empty;
  logic                  fifo_rd_almost_empty;
  logic [DATA_WIDTH-1:0] tx_DATA;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  busy;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_DATA,
    input  fifo_rd_empty,
    input  fifo_rd_almost_empty,
    output tx_DATA,
    output tx_valid,
    input  tx_ready,
    output busy
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_DATA,
    output fifo_rd_empty,
    output fifo_rd_almost_empty,
    input  tx_DATA,
    input  tx_valid,
    output tx_ready,
    input  busy
  );
endinterface

// File: rtl/fifo_burst_drain.sv
// rtl/fifo_burst_drain.sv - burst reader from a 1-cycle-latency FIFO into a valid/ready byte stream
module fifo_burst_drain #(
  parameter int DATA_WIDTH     = 8,
  parameter int BURST_LEN      = 16,
  parameter int TIMEOUT_CYCLES = 1200
) (
  input  logic                clk,
  input  logic                rst,
  fifo_burst_drain_if.master  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_FIRE = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [CW-1:0]         burst_cnt_q, burst_cnt_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [1:0]            occ;
  logic                  pop;
  logic                  rd_accept;

  // Reserve a buffer slot for every read in flight so a capture always has room.
  always_comb begin
    occ       = count_q + {1'b0, inflight_q};
    pop       = (count_q != 2'd0) && bus.tx_ready;
    rd_accept = (state_q == BURST) && !bus.fifo_rd_empty && (burst_cnt_q < CNT_MAX)
                && ((occ < 2'd2) || pop);
  end

  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    count_d    = count_q;
    inflight_d = rd_accept;
    if (pop && inflight_q) begin
      if (count_q == 2'd1) begin
        buf0_d = bus.fifo_rd_DATA;
      end else begin
        buf0_d = buf1_q;
        buf1_d = bus.fifo_rd_DATA;
      end
    end else if (pop) begin
      buf0_d  = buf1_q;
      count_d = count_q - 2'd1;
    end else if (inflight_q) begin
      if (count_q == 2'd0) begin
        buf0_d = bus.fifo_rd_DATA;
      end else begin
        buf1_d = bus.fifo_rd_DATA;
      end
      count_d = count_q + 2'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.fifo_rd_empty) begin
          timer_d = '0;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TW'(1);
        end
        if (!bus.fifo_rd_almost_empty || (!bus.fifo_rd_empty && timer_q == TIMER_FIRE)) begin
          state_d     = BURST;
          timer_d     = '0;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (rd_accept) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end
        if (bus.fifo_rd_empty || burst_cnt_d == CNT_MAX) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && count_q == 2'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      burst_cnt_q <= '0;
      count_q     <= 2'd0;
      inflight_q  <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      burst_cnt_q <= burst_cnt_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

  assign bus.fifo_rd_en = rd_accept;
  assign bus.tx_DATA    = buf0_q;
  assign bus.tx_valid   = (count_q != 2'd0);
  assign bus.busy       = (state_q != IDLE) || (count_q != 2'd0);
endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb/tb_fifo_burst_drain.sv - directed scoreboard bench for fifo_burst_drain
module tb_fifo_burst_drain;
  localparam int DW = 8;
  localparam int BL = 16;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_burst_drain_if #(.DATA_WIDTH(DW)) bus ();

  fifo_burst_drain #(
    .DATA_WIDTH    (DW),
    .BURST_LEN     (BL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // FIFO model: bench writes wr_ptr, model writes rd_ptr and the latched read data.
  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       force_ae = 1'b0;
  logic       flush_req = 1'b0;
  logic [7:0] fifo_data = '0;

  assign bus.fifo_rd_empty        = (rd_ptr == wr_ptr);
  assign bus.fifo_rd_almost_empty = force_ae ? 1'b0 : ((wr_ptr - rd_ptr) <= 4);
  assign bus.fifo_rd_DATA         = fifo_data;

  always @(posedge clk) begin
    if (flush_req) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd_en && !bus.fifo_rd_empty) begin
      fifo_data <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  int         runs [$];
  int         run_len = 0;
  int         n_rx = 0;
  logic       rand_ready = 1'b0;
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(b);
  endtask

  // One clock: monitor at negedge, then new stimulus 1 time unit after posedge.
  task automatic step();
    logic [7:0] want;
    @(negedge clk);
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (bus.tx_valid && bus.tx_ready) begin
        check("extra_byte", exp_q.size() != 0, 1);
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        check("tx_data", bus.tx_DATA, want);
        n_rx++;
      end
      if (hold_v) begin
        check("hold_valid", bus.tx_valid, 1);
        check("hold_data", bus.tx_DATA, hold_d);
      end
      hold_v = bus.tx_valid && !bus.tx_ready;
      hold_d = bus.tx_DATA;
      check("rd_on_empty", bus.fifo_rd_en && bus.fifo_rd_empty, 0);
      check("occupancy", (dut.count_q + dut.inflight_q) <= 2, 1);
    end
    if (bus.fifo_rd_en && !bus.fifo_rd_empty) begin
      run_len++;
    end else if (run_len > 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
    @(posedge clk);
    #1;
    if (rand_ready) bus.tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done"}, n < budget, 1);
  endtask

  initial begin
    int cnt;
    int rx0;
    int exp_runs [3] = '{16, 16, 8};
    bus.tx_ready = 1'b1;

    // Reset held with data present; then the timeout path releases a partial burst.
    @(posedge clk);
    #1;
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    for (int i = 0; i < 3; i++) begin
      check("rst_valid", bus.tx_valid, 0);
      check("rst_data", bus.tx_DATA, 0);
      check("rst_rd_en", bus.fifo_rd_en, 0);
      check("rst_busy", bus.busy, 0);
      step();
    end
    rst = 1'b0;
    check("rel_valid", bus.tx_valid, 0);
    check("rel_data", bus.tx_DATA, 0);
    check("rel_rd_en", bus.fifo_rd_en, 0);
    check("rel_busy", bus.busy, 0);
    runs.delete();
    cnt = 0;
    while (!bus.fifo_rd_en && cnt < 60) begin
      cnt++;
      step();
    end
    check("timeout_wait", (cnt >= TO - 1) && (cnt <= TO), 1);
    drain("timeout", 200);
    check("timeout_runs", runs.size(), 1);
    check("timeout_run0", runs.size() > 0 ? runs[0] : -1, 3);
    check("timeout_busy", bus.busy, 0);
    check("timeout_valid", bus.tx_valid, 0);

    // Full-rate bursts from a 40-byte preload.
    runs.delete();
    for (int i = 0; i < 40; i++) push_byte(8'(i));
    drain("fullrate", 400);
    check("fr_nruns", runs.size(), 3);
    for (int i = 0; i < 3; i++)
      check("fr_run", runs.size() > i ? runs[i] : -1, exp_runs[i]);

    // Random backpressure on 64 bytes.
    rx0 = n_rx;
    rand_ready = 1'b1;
    for (int i = 0; i < 64; i++) push_byte(8'($urandom_range(0, 255)));
    drain("backpressure", 3000);
    check("bp_count", n_rx - rx0, 64);
    rand_ready = 1'b0;
    bus.tx_ready = 1'b1;

    // Early empty with almost_empty forced low.
    runs.delete();
    force_ae = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    drain("early", 200);
    for (int i = 0; i < 6; i++) begin
      step();
      check("early_timer", dut.timer_q, 0);
    end
    check("early_nruns", runs.size(), 1);
    check("early_run0", runs.size() > 0 ? runs[0] : -1, 5);
    force_ae = 1'b0;

    // Reset while the output buffer is full and the stream is stalled.
    bus.tx_ready = 1'b0;
    force_ae = 1'b1;
    for (int i = 0; i < 8; i++) push_byte(8'h80 + 8'(i));
    for (int i = 0; i < 8; i++) step();
    check("pre_rst_valid", bus.tx_valid, 1);
    rst = 1'b1;
    flush_req = 1'b1;
    step();
    rst = 1'b0;
    flush_req = 1'b0;
    exp_q.delete();
    check("mid_rst_valid", bus.tx_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_rd_en", bus.fifo_rd_en, 0);
    force_ae = 1'b0;
    bus.tx_ready = 1'b1;
    rx0 = n_rx;
    push_byte(8'h55);
    push_byte(8'h66);
    drain("reload", 200);
    for (int i = 0; i < 30; i++) step();
    check("reload_count", n_rx - rx0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
